// File: rtl/muldiv_iter.sv
// muldiv_iter: radix-2 iterative signed/unsigned multiply and restoring divide; define MULDIV_UNSIGNED_EN to let op[1] select unsigned ops
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             mult_overflow,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, prod;
  logic [WIDTH-1:0] dvs, abs_a, abs_b, q_fix, r_fix, hi_n, lo_n;
  logic [WIDTH:0] sum, rem_sh, diff;
  logic uns, sa, sb, dz, is_div, uns_q, neg_lo, neg_hi;
`ifdef MULDIV_UNSIGNED_EN
  assign uns = op[1];
`else
  assign uns = 1'b0 & op[1];
`endif
  assign sa = a[WIDTH-1] & ~uns;
  assign sb = b[WIDTH-1] & ~uns;
  assign abs_a = sa ? -a : a;
  assign abs_b = sb ? -b : b;
  assign dz = op[0] && b == '0;
  assign busy = state == CALC || state == FIX;
  always_comb begin
    nxt = state == IDLE ? (start ? (dz ? DONE : CALC) : IDLE) :
          state == CALC ? (cnt == CW'(WIDTH-1) ? FIX : CALC) :
          state == FIX  ? DONE : (done ? IDLE : DONE);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      done <= 1'b0;
    end else begin
      state <= nxt;
      done <= state == FIX || (state == DONE && !done);
    end
  end
  // sum: shift-add step; rem_sh/diff: restoring-divide trial subtraction
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvs} : '0);
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    diff = rem_sh - {1'b0, dvs};
    prod = neg_lo ? -acc : acc;
    q_fix = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_fix = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    hi_n = is_div ? r_fix : prod[2*WIDTH-1:WIDTH];
    lo_n = is_div ? q_fix : prod[WIDTH-1:0];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      dvs <= '0;
      cnt <= '0;
      is_div <= 1'b0;
      uns_q <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      hi <= '0;
      lo <= '0;
      mult_overflow <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (state == IDLE && start) begin
      acc <= {{WIDTH{1'b0}}, op[0] ? abs_a : abs_b};
      dvs <= op[0] ? abs_b : abs_a;
      cnt <= '0;
      is_div <= op[0];
      uns_q <= uns;
      neg_lo <= sa ^ sb;
      neg_hi <= sa;
      mult_overflow <= 1'b0;
      div_by_zero <= dz;
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      acc <= !is_div ? {sum, acc[WIDTH-1:1]} :
             diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} :
                           {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else if (state == FIX) begin
      hi <= hi_n;
      lo <= lo_n;
      mult_overflow <= !is_div && (uns_q ? hi_n != '0 : hi_n != {WIDTH{lo_n[WIDTH-1]}});
    end
  end
endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed checks of muldiv_iter at WIDTH = 32
module tb_muldiv_iter;
  logic clk = 1'b0, reset, start, busy, done, mult_overflow, div_by_zero;
  logic [1:0] op;
  logic [31:0] a, b, hi, lo;
  int tests = 0, fails = 0, lat, bcnt, seen;

  muldiv_iter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .mult_overflow(mult_overflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input bit poke, output int l, output int bc);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    l = 0; bc = 0;
    while (!done && l < 100) begin
      if (busy) bc++;
      start = poke && l == 5;
      if (start) begin op = ~o; a = 32'h1234; b = 32'h5; end
      @(posedge clk); #1;
      l++;
    end
    start = 1'b0;
    @(posedge clk); #1;
    check("done_pulse_width", {63'd0, done}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    check("reset_busy_done", {62'd0, busy, done}, 64'd0);
    check("reset_flags", {62'd0, mult_overflow, div_by_zero}, 64'd0);
    @(negedge clk) reset = 1'b0;

    run(2'b00, 32'd7, 32'hFFFFFFFD, 1'b1, lat, bcnt);
    check("smul_hi", {32'd0, hi}, 64'hFFFFFFFF);
    check("smul_lo", {32'd0, lo}, 64'hFFFFFFEB);
    check("smul_ovf", {63'd0, mult_overflow}, 64'd0);
    check("smul_latency", 64'(lat), 64'd33);
    check("smul_busy_cycles", 64'(bcnt), 64'd33);

    run(2'b01, 32'hFFFFFFF9, 32'd2, 1'b0, lat, bcnt);
    check("sdiv_lo", {32'd0, lo}, 64'hFFFFFFFD);
    check("sdiv_hi", {32'd0, hi}, 64'hFFFFFFFF);

    run(2'b01, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat, bcnt);
    check("minneg_lo", {32'd0, lo}, 64'h80000000);
    check("minneg_hi", {32'd0, hi}, 64'd0);
    check("minneg_flags", {62'd0, mult_overflow, div_by_zero}, 64'd0);

    run(2'b01, 32'd5, 32'd2, 1'b0, lat, bcnt);
    check("prior_hi", {32'd0, hi}, 64'd1);
    check("prior_lo", {32'd0, lo}, 64'd2);

    run(2'b01, 32'd5, 32'd0, 1'b0, lat, bcnt);
    check("dz_flag", {63'd0, div_by_zero}, 64'd1);
    check("dz_latency", 64'(lat), 64'd1);
    check("dz_busy_cycles", 64'(bcnt), 64'd0);
    check("dz_hi_kept", {32'd0, hi}, 64'd1);
    check("dz_lo_kept", {32'd0, lo}, 64'd2);

    run(2'b00, 32'h00010000, 32'h00010000, 1'b0, lat, bcnt);
    check("ovf_hi", {32'd0, hi}, 64'd1);
    check("ovf_lo", {32'd0, lo}, 64'd0);
    check("ovf_flag", {63'd0, mult_overflow}, 64'd1);
    check("dz_cleared", {63'd0, div_by_zero}, 64'd0);

    run(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, bcnt);
`ifdef MULDIV_UNSIGNED_EN
    check("umul_hi", {32'd0, hi}, 64'hFFFFFFFE);
    check("umul_lo", {32'd0, lo}, 64'd1);
    check("umul_ovf", {63'd0, mult_overflow}, 64'd1);
`else
    check("umul_hi", {32'd0, hi}, 64'd0);
    check("umul_lo", {32'd0, lo}, 64'd1);
    check("umul_ovf", {63'd0, mult_overflow}, 64'd0);
`endif

    @(negedge clk);
    op = 2'b00; a = 32'd7; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_hi", {32'd0, hi}, 64'd0);
    check("abort_lo", {32'd0, lo}, 64'd0);
    check("abort_busy_done", {62'd0, busy, done}, 64'd0);
    check("abort_flags", {62'd0, mult_overflow, div_by_zero}, 64'd0);
    @(negedge clk) reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("abort_no_done", 64'(seen), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
